// File: rtl/block_painter_pkg.sv
// block_painter_pkg: shared FSM states, board limits and coordinate/address types
package block_painter_pkg;
    typedef enum logic [2:0] {IDLE, LATCH, ERASE, DRAW, DONE} state_t;
    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    typedef logic [6:0]  cell_t;
    typedef logic [18:0] pix_addr_t;
    function automatic logic on_board(cell_t x, cell_t y);
        return (x < cell_t'(BOARD_COLS)) && (y < cell_t'(BOARD_ROWS));
    endfunction
endpackage

// File: rtl/block_painter_cell_addr_gen.sv
// cell_addr_gen: maps board cell (cell_x, cell_y) and in-cell pixel (px, py) to a framebuffer address
//   ports: cell_x, cell_y, px, py in; addr out (y*SCREEN_W + x, 19-bit)
module cell_addr_gen
    import block_painter_pkg::*;
#(
    parameter int CELL_PX  = 16,
    parameter int BOARD_X0 = 240,
    parameter int BOARD_Y0 = 80,
    parameter int SCREEN_W = 640
) (
    input  cell_t     cell_x,
    input  cell_t     cell_y,
    input  cell_t     px,
    input  cell_t     py,
    output pix_addr_t addr
);
    pix_addr_t x, y;
    always_comb begin
        x = pix_addr_t'(BOARD_X0) + pix_addr_t'(cell_x) * pix_addr_t'(CELL_PX) + pix_addr_t'(px);
        y = pix_addr_t'(BOARD_Y0) + pix_addr_t'(cell_y) * pix_addr_t'(CELL_PX) + pix_addr_t'(py);
        addr = y * pix_addr_t'(SCREEN_W) + x;
    end
endmodule

// File: rtl/block_painter.sv
// block_painter: repaints the falling piece into VRAM on each frame tick (erase old cells, draw new ones)
//   ports: Clk, Reset (sync, active-low), frame_clk tick, block*Pos/Prev cell coords [0..3], blockColor;
//          vram_addr/vram_wdata/vram_we with vram_ack handshake; busy, paint_done pulse
module block_painter
    import block_painter_pkg::*;
#(
    parameter int          CELL_PX  = 16,
    parameter int          BOARD_X0 = 240,
    parameter int          BOARD_Y0 = 80,
    parameter int          SCREEN_W = 640,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  cell_t       blockXPos  [16],
    input  cell_t       blockYPos  [16],
    input  cell_t       blockXPrev [16],
    input  cell_t       blockYPrev [16],
    input  logic [15:0] blockColor,
    output pix_addr_t   vram_addr,
    output logic [15:0] vram_wdata,
    output logic        vram_we,
    input  logic        vram_ack,
    output logic        busy,
    output logic        paint_done
);
    localparam cell_t LAST = cell_t'(CELL_PX - 1);
    state_t      state, state_n;
    logic [2:0]  sync;
    logic        pending, edge_s, go, move, still, step, cell_end;
    cell_t       cx [4], cy [4], qx [4], qy [4];
    cell_t       dx0, dy0, sx, sy, px, py;
    logic [15:0] color;
    logic [3:0]  rem, rem_n, emask, vmask;
    logic [1:0]  idx;
    pix_addr_t   gen_addr;

    cell_addr_gen #(.CELL_PX(CELL_PX), .BOARD_X0(BOARD_X0), .BOARD_Y0(BOARD_Y0), .SCREEN_W(SCREEN_W)) u_gen (
        .cell_x(sx), .cell_y(sy), .px(px), .py(py), .addr(gen_addr)
    );

    // emask: prev cells still to erase (on board, not overlapped by a current cell); vmask: current cells to draw
    always_comb begin
        edge_s = sync[1] & ~sync[2];
        go = edge_s | pending;
        dx0 = cx[0] - qx[0];
        dy0 = cy[0] - qy[0];
        move = (dx0 inside {7'd0, 7'd1, 7'h7f}) && (dy0 <= 7'd1);
        for (int i = 0; i < 4; i++) begin
            vmask[i] = on_board(cx[i], cy[i]);
            emask[i] = on_board(qx[i], qy[i]);
            for (int j = 0; j < 4; j++)
                if (qx[i] == cx[j] && qy[i] == cy[j]) emask[i] = 1'b0;
            if (cell_t'(cx[i] - qx[i]) != dx0 || cell_t'(cy[i] - qy[i]) != dy0) move = 1'b0;
        end
        still = move && dx0 == '0 && dy0 == '0;
        // the current cell is always the lowest remaining bit, so skipped cells cost no cycles
        idx = rem[0] ? 2'd0 : rem[1] ? 2'd1 : rem[2] ? 2'd2 : 2'd3;
        rem_n = rem & ~(4'b1 << idx);
        sx = state == ERASE ? qx[idx] : cx[idx];
        sy = state == ERASE ? qy[idx] : cy[idx];
        vram_we = state == ERASE || state == DRAW;
        vram_addr = vram_we ? gen_addr : '0;
        vram_wdata = state == ERASE ? BG_COLOR : state == DRAW ? color : '0;
        busy = state != IDLE;
        paint_done = state == DONE;
        step = vram_we && vram_ack;
        cell_end = px == LAST && py == LAST;
        state_n = state;
        case (state)
            IDLE:    state_n = go ? LATCH : IDLE;
            LATCH:   state_n = still ? DONE : (move && emask != '0) ? ERASE : vmask != '0 ? DRAW : DONE;
            ERASE:   if (step && cell_end && rem_n == '0) state_n = vmask != '0 ? DRAW : DONE;
            DRAW:    if (step && cell_end && rem_n == '0) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            sync <= '0;
            pending <= 1'b0;
            rem <= '0;
            px <= '0;
            py <= '0;
            color <= '0;
            for (int i = 0; i < 4; i++) begin
                cx[i] <= '0;
                cy[i] <= '0;
                qx[i] <= '0;
                qy[i] <= '0;
            end
        end else begin
            state <= state_n;
            sync <= {sync[1:0], frame_clk};
            if (state == IDLE && go) begin
                pending <= 1'b0;
                color <= blockColor;
                for (int i = 0; i < 4; i++) begin
                    cx[i] <= blockXPos[i];
                    cy[i] <= blockYPos[i];
                    qx[i] <= blockXPrev[i];
                    qy[i] <= blockYPrev[i];
                end
            end else if (edge_s && state != IDLE) begin
                pending <= 1'b1;
            end
            if (state == LATCH) begin
                rem <= state_n == ERASE ? emask : vmask;
            end else if (step) begin
                px <= px == LAST ? '0 : px + 7'd1;
                if (px == LAST) py <= py == LAST ? '0 : py + 7'd1;
                if (cell_end) rem <= (rem_n == '0 && state == ERASE) ? vmask : rem_n;
            end
        end
    end
endmodule

// File: tb/tb_block_painter.sv
// tb_block_painter: directed scoreboard bench for block_painter
module tb_block_painter;
    logic        Clk = 1'b0, Reset = 1'b0, frame_clk = 1'b0, vram_ack = 1'b1;
    logic [6:0]  blockXPos [16], blockYPos [16], blockXPrev [16], blockYPrev [16];
    logic [15:0] blockColor = 16'h0;
    logic [18:0] vram_addr;
    logic [15:0] vram_wdata;
    logic        vram_we, busy, paint_done;
    int          errors = 0, checks = 0, done_cnt = 0, wr_cnt = 0, bg_cnt = 0;
    int          base_wr, base_done, base_bg;
    logic [34:0] sb [$];
    logic [34:0] exp_w;
    logic [18:0] a0;
    logic [15:0] d0;

    always #5 Clk = ~Clk;

    block_painter dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .blockXPos(blockXPos), .blockYPos(blockYPos), .blockXPrev(blockXPrev), .blockYPrev(blockYPrev),
        .blockColor(blockColor), .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .vram_ack(vram_ack), .busy(busy), .paint_done(paint_done)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one clock; samples the DUT on the falling edge and scores any accepted write
    task automatic tick();
        @(negedge Clk);
        if (paint_done) done_cnt++;
        if (vram_we && vram_ack) begin
            wr_cnt++;
            if (vram_wdata == 16'h0000) bg_cnt++;
            if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else begin
                exp_w = sb.pop_front();
                chk("sb_write", {29'd0, vram_addr, vram_wdata}, {29'd0, exp_w});
            end
        end
    endtask

    task automatic push_cell(int x, int y, logic [15:0] c);
        for (int py = 0; py < 16; py++)
            for (int px = 0; px < 16; px++)
                sb.push_back({19'((80 + y * 16 + py) * 640 + 240 + x * 16 + px), c});
    endtask

    task automatic set_cells(bit prv, int x0, int y0, int x1, int y1, int x2, int y2, int x3, int y3);
        int xs [4];
        int ys [4];
        xs = '{x0, x1, x2, x3};
        ys = '{y0, y1, y2, y3};
        for (int i = 0; i < 4; i++)
            if (prv) begin
                blockXPrev[i] = 7'(xs[i]);
                blockYPrev[i] = 7'(ys[i]);
            end else begin
                blockXPos[i] = 7'(xs[i]);
                blockYPos[i] = 7'(ys[i]);
            end
    endtask

    task automatic pulse();
        frame_clk = 1'b1;
        repeat (4) tick();
        frame_clk = 1'b0;
        repeat (4) tick();
    endtask

    task automatic wait_we(string tag, int budget);
        int n = 0;
        while (!vram_we && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(vram_we), 64'd1);
    endtask

    task automatic wait_done(string tag, int budget);
        int n = 0;
        while (!paint_done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(paint_done), 64'd1);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            blockXPos[i] = '0;
            blockYPos[i] = '0;
            blockXPrev[i] = '0;
            blockYPrev[i] = '0;
        end
        repeat (3) tick();
        chk("rst_we", 64'(vram_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(paint_done), 64'd0);
        chk("rst_addr", 64'(vram_addr), 64'd0);
        chk("rst_wdata", 64'(vram_wdata), 64'd0);
        Reset = 1'b1;
        repeat (3) tick();

        // shift right: only non-overlapped prev cells erased, all current cells drawn
        set_cells(1, 4, 0, 5, 0, 5, 1, 6, 1);
        set_cells(0, 5, 0, 6, 0, 6, 1, 7, 1);
        blockColor = 16'h0f00;
        push_cell(4, 0, 16'h0000);
        push_cell(5, 1, 16'h0000);
        push_cell(5, 0, 16'h0f00);
        push_cell(6, 0, 16'h0f00);
        push_cell(6, 1, 16'h0f00);
        push_cell(7, 1, 16'h0f00);
        base_wr = wr_cnt;
        base_bg = bg_cnt;
        frame_clk = 1'b1;
        wait_we("shift_we", 20);
        chk("shift_first_addr", 64'(vram_addr), 64'd51504);
        frame_clk = 1'b0;
        wait_done("shift_done", 3000);
        chk("shift_writes", 64'(wr_cnt - base_wr), 64'd1536);
        chk("shift_bg_writes", 64'(bg_cnt - base_bg), 64'd512);
        chk("shift_sb_empty", 64'(sb.size()), 64'd0);
        chk("shift_idle", 64'(busy), 64'd0);

        // spawn: piece changed shape, erase skipped entirely
        set_cells(1, 4, 18, 5, 18, 4, 19, 5, 19);
        set_cells(0, 4, 0, 5, 0, 5, 1, 6, 1);
        blockColor = 16'h00f0;
        push_cell(4, 0, 16'h00f0);
        push_cell(5, 0, 16'h00f0);
        push_cell(5, 1, 16'h00f0);
        push_cell(6, 1, 16'h00f0);
        base_wr = wr_cnt;
        base_bg = bg_cnt;
        pulse();
        wait_done("spawn_done", 3000);
        chk("spawn_writes", 64'(wr_cnt - base_wr), 64'd1024);
        chk("spawn_bg_writes", 64'(bg_cnt - base_bg), 64'd0);
        chk("spawn_sb_empty", 64'(sb.size()), 64'd0);

        // no motion: no writes, paint_done two cycles after the synchronised edge
        set_cells(1, 4, 0, 5, 0, 5, 1, 6, 1);
        base_wr = wr_cnt;
        base_done = done_cnt;
        frame_clk = 1'b1;
        tick();
        tick();
        chk("still_busy_sync", 64'(busy), 64'd0);
        tick();
        chk("still_busy_latch", 64'(busy), 64'd1);
        chk("still_done_early", 64'(paint_done), 64'd0);
        tick();
        chk("still_done", 64'(paint_done), 64'd1);
        frame_clk = 1'b0;
        repeat (10) tick();
        chk("still_writes", 64'(wr_cnt - base_wr), 64'd0);
        chk("still_done_cnt", 64'(done_cnt - base_done), 64'd1);

        // ack stall on first write; two off-board cells skipped
        set_cells(0, 0, 0, 1, 0, 10, 0, 0, 20);
        blockColor = 16'h1234;
        push_cell(0, 0, 16'h1234);
        push_cell(1, 0, 16'h1234);
        vram_ack = 1'b0;
        base_wr = wr_cnt;
        frame_clk = 1'b1;
        wait_we("stall_we", 20);
        frame_clk = 1'b0;
        a0 = vram_addr;
        d0 = vram_wdata;
        chk("stall_first_addr", 64'(a0), 64'd51440);
        chk("stall_first_data", 64'(d0), 64'h1234);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_addr", 64'(vram_addr), 64'(a0));
            chk("stall_wdata", 64'(vram_wdata), 64'(d0));
            chk("stall_we_held", 64'(vram_we), 64'd1);
        end
        chk("stall_count", 64'(wr_cnt - base_wr), 64'd0);
        @(posedge Clk);
        #1 vram_ack = 1'b1;
        wait_done("stall_done", 2000);
        chk("stall_writes", 64'(wr_cnt - base_wr), 64'd512);
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);

        // edges while busy coalesce into exactly one more update
        set_cells(1, 4, 18, 5, 18, 4, 19, 5, 19);
        set_cells(0, 4, 0, 5, 0, 5, 1, 6, 1);
        blockColor = 16'h00f0;
        for (int k = 0; k < 2; k++) begin
            push_cell(4, 0, 16'h00f0);
            push_cell(5, 0, 16'h00f0);
            push_cell(5, 1, 16'h00f0);
            push_cell(6, 1, 16'h00f0);
        end
        base_wr = wr_cnt;
        base_done = done_cnt;
        pulse();
        chk("coal_busy", 64'(busy), 64'd1);
        repeat (3) pulse();
        for (int n = 0; n < 5000 && done_cnt < base_done + 2; n++) tick();
        repeat (30) tick();
        chk("coal_done_cnt", 64'(done_cnt - base_done), 64'd2);
        chk("coal_writes", 64'(wr_cnt - base_wr), 64'd2048);
        chk("coal_sb_empty", 64'(sb.size()), 64'd0);

        // reset mid-draw with a pending edge: everything discarded
        push_cell(4, 0, 16'h00f0);
        push_cell(5, 0, 16'h00f0);
        push_cell(5, 1, 16'h00f0);
        push_cell(6, 1, 16'h00f0);
        base_wr = wr_cnt;
        pulse();
        pulse();
        for (int n = 0; n < 500 && wr_cnt < base_wr + 100; n++) tick();
        chk("rst_mid_reached", 64'(wr_cnt - base_wr), 64'd100);
        Reset = 1'b0;
        tick();
        chk("rst_mid_we", 64'(vram_we), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        tick();
        Reset = 1'b1;
        sb.delete();
        base_wr = wr_cnt;
        base_done = done_cnt;
        repeat (40) tick();
        chk("rst_after_writes", 64'(wr_cnt - base_wr), 64'd0);
        chk("rst_after_done", 64'(done_cnt - base_done), 64'd0);
        chk("rst_after_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/block_painter.md
BLOCK_PAINTER -- requirements
Module: block_painter

Interface
REQ-001 Param CELL_PX, 16: pixel edge length of one board square.
REQ-002 Param BOARD_X0, 240: screen X of board column 0, in pixels.
REQ-003 Param BOARD_Y0, 80: screen Y of board row 0, in pixels.
REQ-004 Param SCREEN_W, 640: framebuffer line pitch in pixels.
REQ-005 Param BG_COLOR, 16'h0000: erase colour.
REQ-006 Clk  in  1: single system clock; all logic on posedge Clk.
REQ-007 Reset  in  1: reset is synchronous and active-low.
REQ-008 frame_clk  in  1: frame tick from the piece-logic block, level signal.
REQ-009 blockXPos, blockYPos  in  7 x16: current square coordinates; only [0..3] used.
REQ-010 blockXPrev, blockYPrev  in  7 x16: previous square coordinates; only [0..3] used.
REQ-011 blockColor  in  16: colour of the current piece.
REQ-012 vram_addr  out  19: pixel address, y*SCREEN_W + x.
REQ-013 vram_wdata  out  16: pixel colour.
REQ-014 vram_we  out  1: write request.
REQ-015 vram_ack  in  1: write accepted this cycle.
REQ-016 busy  out  1: high whenever FSM not IDLE.
REQ-017 paint_done  out  1: one-cycle pulse at the end of each update.

Function
REQ-018 frame_clk SHALL pass a 2-flop synchroniser; a rising edge SHALL be detected on the synchronised copy.
REQ-019 FSM states SHALL be IDLE, LATCH, ERASE, DRAW, DONE.
REQ-020 IDLE->LATCH on a detected edge or a set pending flag; LATCH SHALL snapshot all cur/prev coordinates [0..3] and blockColor, then clear pending.
REQ-021 An edge arriving while busy SHALL set pending; multiple edges SHALL coalesce into one pending update.
REQ-022 LATCH SHALL compute dx_i = cur_x-prev_x and dy_i = cur_y-prev_y; move = all four (dx,dy) identical, dx in {-1,0,+1}, dy in {0,+1}.
REQ-023 If move and dx=dy=0: LATCH->DONE with no writes.
REQ-024 If move is false (piece locked, new piece spawned): ERASE SHALL be skipped (LATCH->DRAW) so locked squares survive.
REQ-025 ERASE SHALL visit prev cells 0..3 in order, writing BG_COLOR to all CELL_PX*CELL_PX pixels, row-major (px inner, py outer).
REQ-026 A prev cell equal to any current cell, or with X>9 or Y>19, SHALL be skipped with zero write cycles.
REQ-027 DRAW SHALL visit current cells 0..3 likewise with latched colour; cells with X>9 or Y>19 SHALL be skipped.
REQ-028 Pixel x = BOARD_X0 + X*CELL_PX + px; y = BOARD_Y0 + Y*CELL_PX + py; address arithmetic SHALL be 19-bit unsigned without truncation of intermediates.
REQ-029 vram_we, vram_addr and vram_wdata SHALL be held stable until the cycle vram_ack=1; the pixel counter SHALL advance only on vram_we&&vram_ack.
REQ-030 vram_we SHALL remain low in IDLE, LATCH and DONE.
REQ-031 First vram_we SHALL assert in the cycle after LATCH; with vram_ack tied high, one pixel SHALL be written per cycle.
REQ-032 DONE SHALL pulse paint_done for one cycle and return to IDLE.
REQ-033 Input changes after LATCH SHALL NOT affect the update in progress.

Reset
REQ-034 On Reset=0 at a Clk edge: FSM IDLE; vram_we, busy, paint_done = 0; vram_addr, vram_wdata = 0; pending, counters, synchroniser and snapshot = 0.
REQ-035 Reset mid-ERASE/DRAW SHALL drop vram_we at that edge and discard the update and pending.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, BOARD_COLS=10, BOARD_ROWS=20, the cell-coordinate typedef (7 bit) and the pixel-address typedef (19 bit).
REQ-037 One sub-module, cell_addr_gen, SHALL map (X, Y, px, py) to vram_addr combinationally.

Verification
REQ-038 Shift right: prev {(4,0),(5,0),(5,1),(6,1)}, cur = each X+1, colour 16'h0f00, ack=1 -> erase cells (4,0),(5,1) only; draw all 4 cells; 6*256 = 1536 writes; first erase address 80*640+304 = 51504.
REQ-039 Spawn: prev {(4,18),(5,18),(4,19),(5,19)}, cur {(4,0),(5,0),(5,1),(6,1)} -> no BG_COLOR writes; 1024 draw writes.
REQ-040 No motion: cur=prev -> vram_we never asserted; paint_done pulses 2 cycles after the synchronised edge.
REQ-041 vram_ack low for 5 cycles on the first write -> vram_addr and vram_wdata stable through those cycles; pixel count unchanged.
REQ-042 3 frame_clk edges during one update -> exactly one further update; 2 paint_done pulses in total.
REQ-043 Reset=0 during DRAW write 100 -> vram_we=0 next cycle; busy=0; no update resumes after release.
